// File: rtl/bit_serializer_pkg.sv
// Shared constants for the bit serializer and its downstream sequence detector.
package bit_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial streamer: valid/ready word intake, one bit per clk on x,
// gapless back-to-back words.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no word in flight, x = IDLE_LEVEL, ready for a word
// ST_SHIFT | word bits on x, cnt = index of the bit currently on x
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int   WIDTH      = DEFAULT_WIDTH,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             last_bit;
   logic             can_take;
   logic             xfer;

   assign last_bit = (state == ST_SHIFT) && (cnt == LAST);
   assign can_take = (state == ST_IDLE) || last_bit;
   assign xfer     = din_valid && can_take && !clr;

   // Gating with reset keeps the handshake closed for the whole reset window.
   assign din_ready = reset && can_take;
   assign busy      = (state == ST_SHIFT);
   assign x_valid   = (state == ST_SHIFT);
   assign word_done = last_bit;
   assign x         = (state == ST_SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0])
                                          : IDLE_LEVEL;

   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      if (clr) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else if (xfer) begin
         state_nxt = ST_SHIFT;
         sreg_nxt  = din;
         cnt_nxt   = '0;
      end else if (state == ST_SHIFT) begin
         if (last_bit) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end else begin
            sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            cnt_nxt  = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances share stimulus.
module tb_bit_serializer;

   logic       clk;
   logic       reset;
   logic       clr;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready, x, x_valid, word_done, busy;
   logic       l_din_ready, l_x, l_x_valid, l_word_done, l_busy;

   int errors = 0;
   int checks = 0;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
      .clk(clk), .reset(reset), .clr(clr), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .x(x), .x_valid(x_valid), .word_done(word_done), .busy(busy)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .clr(clr), .din(din), .din_valid(din_valid),
      .din_ready(l_din_ready), .x(l_x), .x_valid(l_x_valid), .word_done(l_word_done),
      .busy(l_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_x"},       32'(x),         32'd0);
      chk({tag, "_xvalid"},  32'(x_valid),   32'd0);
      chk({tag, "_busy"},    32'(busy),      32'd0);
      chk({tag, "_wdone"},   32'(word_done), 32'd0);
   endtask

   logic [15:0] stream;
   logic [7:0]  bp_din [0:6];
   logic [3:0]  hist;
   int          pulses;
   int          dets;

   initial begin
      reset = 1'b0; clr = 1'b0; din = 8'h00; din_valid = 1'b0;
      bp_din[0] = 8'h12; bp_din[1] = 8'hFE; bp_din[2] = 8'h00; bp_din[3] = 8'h77;
      bp_din[4] = 8'h81; bp_din[5] = 8'hC3; bp_din[6] = 8'h5A;

      // reset state
      #12;
      chk_idle("rst");
      chk("rst_ready", 32'(din_ready), 32'd0);
      step();
      reset = 1'b1;
      #1;
      chk("rel_ready", 32'(din_ready), 32'd1);

      // single word 0xAA, MSB first
      din = 8'hAA; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      stream[7:0] = 8'hAA;
      for (int i = 0; i < 8; i++) begin
         chk("s_x",      32'(x),         32'(stream[7-i]));
         chk("s_xvalid", 32'(x_valid),   32'd1);
         chk("s_busy",   32'(busy),      32'd1);
         chk("s_wdone",  32'(word_done), 32'(i == 7));
         step();
      end
      chk_idle("s_end");
      chk("s_end_ready", 32'(din_ready), 32'd1);

      // back-to-back 0xA5, 0x0F
      din = 8'hA5; din_valid = 1'b1;
      step();
      din = 8'h0F;
      stream = 16'b1010_0101_0000_1111;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) din_valid = 1'b0;
         chk("b2b_x",      32'(x),         32'(stream[15-i]));
         chk("b2b_xvalid", 32'(x_valid),   32'd1);
         chk("b2b_ready",  32'(din_ready), 32'((i == 7) || (i == 15)));
         if (word_done) pulses++;
         step();
      end
      chk("b2b_pulses", 32'(pulses), 32'd2);
      chk_idle("b2b_end");

      // backpressure: only the word present at word_done is taken
      din = 8'h11; din_valid = 1'b1;
      step();
      stream = {8'h11, 8'h3C};
      for (int i = 0; i < 16; i++) begin
         if (i < 7)       din = bp_din[i];
         else if (i == 7) din = 8'h3C;
         else begin
            din_valid = 1'b0;
            din       = 8'hFF;
         end
         chk("bp_x",     32'(x),         32'(stream[15-i]));
         chk("bp_wdone", 32'(word_done), 32'((i == 7) || (i == 15)));
         step();
      end
      chk_idle("bp_end");

      // LSB-first instance, 0x01
      din = 8'h01; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("lsb_x",      32'(l_x),         32'(i == 0));
         chk("lsb_xvalid", 32'(l_x_valid),   32'd1);
         chk("lsb_wdone",  32'(l_word_done), 32'(i == 7));
         chk("msb_x_01",   32'(x),           32'(i == 7));
         step();
      end
      chk("lsb_end_xvalid", 32'(l_x_valid), 32'd0);

      // clr at bit 3 of 0xFF with a word on offer
      din = 8'hFF; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      step(); step(); step();
      chk("clr_pre_x", 32'(x), 32'd1);
      clr = 1'b1; din = 8'h55; din_valid = 1'b1;
      step();
      clr = 1'b0; din_valid = 1'b0;
      chk_idle("clr");
      chk("clr_ready", 32'(din_ready), 32'd1);
      step();
      chk("clr_noacc", 32'(x_valid), 32'd0);
      chk("clr_ready2", 32'(din_ready), 32'd1);

      // clr wins over a live handshake in IDLE
      clr = 1'b1; din = 8'h55; din_valid = 1'b1;
      step();
      clr = 1'b0; din_valid = 1'b0;
      chk("clrwin_xvalid", 32'(x_valid), 32'd0);
      chk("clrwin_busy",   32'(busy),    32'd0);

      // async reset during bit 4
      din = 8'hAA; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      step(); step(); step(); step();
      chk("ar_pre_busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk_idle("ar");
      chk("ar_ready", 32'(din_ready), 32'd0);
      step();
      chk("ar_ready_hold", 32'(din_ready), 32'd0);
      chk("ar_xvalid_hold", 32'(x_valid), 32'd0);
      reset = 1'b1;
      #1;
      chk("ar_rel_ready", 32'(din_ready), 32'd1);
      step();
      chk("ar_noresume", 32'(x_valid), 32'd0);

      // fresh 0xAA after reset, feeding a 1010 detector model
      din = 8'hAA; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      hist = 4'b0000;
      dets = 0;
      stream[7:0] = 8'hAA;
      for (int i = 0; i < 8; i++) begin
         chk("ar2_x", 32'(x), 32'(stream[7-i]));
         if (x_valid) begin
            hist = {hist[2:0], x};
            if (hist == 4'b1010) dets++;
         end
         if (word_done) chk("ar2_hist", 32'(hist), 32'hA);
         step();
      end
      chk("ar2_dets", 32'(dets), 32'd3);
      chk_idle("ar2_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish before 20000");
      $fatal(1);
   end

endmodule
